// File: rtl/maxpool_sequencer.sv
// 2x2 / stride-2 signed max-pool sequencer that owns the read and write master ports.
// Define MAXSEQ_RELU_EN to clamp negative window maxima to zero before they are written.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; latches map geometry and base addresses
// RD_REQ  | read request held until accepted
// RD_WAIT | waiting for read data, reduce into the window accumulator
// WR      | result write held until accepted, then advance window
// DONE    | one-cycle completion pulse
module maxpool_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [31:0]       acc;
  logic [31:0]       acc_nxt;
  logic [31:0]       pool_out;
  logic [DIM_W-1:0]  ow;
  logic [DIM_W-1:0]  oh;
  logic [DIM_W-1:0]  ox;
  logic [DIM_W-1:0]  oy;
  logic [1:0]        wd;
  logic              ox_last;
  logic              oy_last;
  logic              degenerate;

  assign ox_last    = (ox == ow - DIM_W'(1));
  assign oy_last    = (oy == oh - DIM_W'(1));
  assign degenerate = ((width >> 1) == '0) || ((height >> 1) == '0);

  // row_addr points at column 0 of input row 2*oy; wd[1] selects the lower row, wd[0] the right column
  assign rd_addr = row_addr
                 + (wd[1] ? stride : '0)
                 + (ADDR_W'(ox) << 3)
                 + (wd[0] ? ADDR_W'(4) : '0);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // First word of a window loads; later words replace only when strictly greater, so ties keep the earlier value
  always_comb begin
    acc_nxt = acc;
    if ((wd == 2'd0) || ($signed(rd_data) > $signed(acc))) begin
      acc_nxt = rd_data;
    end
  end

  always_comb begin
    pool_out = acc_nxt;
`ifdef MAXSEQ_RELU_EN
    if (acc_nxt[31]) begin
      pool_out = '0;
    end
`else
    pool_out = acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = degenerate ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_ready) begin
          state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        if (rd_valid) begin
          state_nxt = (wd == 2'd3) ? S_WR : S_RD_REQ;
        end
      end
      S_WR: begin
        busy   = 1'b1;
        wr_req = 1'b1;
        if (wr_ready) begin
          state_nxt = (ox_last && oy_last) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_addr  <= '0;
      stride    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      acc       <= '0;
      ow        <= '0;
      oh        <= '0;
      ox        <= '0;
      oy        <= '0;
      wd        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row_addr  <= src_base;
            stride    <= ADDR_W'(width) << 2;
            wr_addr_q <= dst_base;
            ow        <= width >> 1;
            oh        <= height >> 1;
            ox        <= '0;
            oy        <= '0;
            wd        <= '0;
          end
        end
        S_RD_WAIT: begin
          if (rd_valid) begin
            acc <= acc_nxt;
            wd  <= wd + 2'd1;
            if (wd == 2'd3) begin
              wr_data_q <= pool_out;
            end
          end
        end
        S_WR: begin
          if (wr_ready) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(4);
            if (ox_last) begin
              ox       <= '0;
              oy       <= oy + DIM_W'(1);
              row_addr <= row_addr + (stride << 1);
            end else begin
              ox <= ox + DIM_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Bench for maxpool_sequencer: memory responder with optional random stalls, scoreboard
// queues for expected read addresses and expected (address, data) writes.
module tb_maxpool_sequencer;

  localparam int AW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [DW-1:0] width;
  logic [DW-1:0] height;
  logic          busy;
  logic          done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready;

  maxpool_sequencer #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .width(width), .height(height),
    .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd [$];
  wr_t         exp_wr [$];

  int compared   = 0;
  int mismatched = 0;
  int reads      = 0;
  int writes     = 0;
  int done_cnt   = 0;
  bit busy_seen  = 0;
  bit manual     = 0;
  bit stall_en   = 0;
  logic [31:0] last_wr_data = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] win_max(input logic [31:0] v0, v1, v2, v3);
    logic [31:0] v [4];
    logic [31:0] m;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    m = v[0];
    for (int i = 1; i < 4; i++) if ($signed(v[i]) > $signed(m)) m = v[i];
`ifdef MAXSEQ_RELU_EN
    if (m[31]) m = '0;
`endif
    return m;
  endfunction

  // Memory responder; also checks request exclusivity and request stability under stall
  initial begin : responder
    int rd_state = 0;
    int rd_cnt = 0;
    int rd_gap = 0;
    int wr_gap = 0;
    bit rd_stalling = 0;
    bit wr_stalling = 0;
    logic [31:0] rd_first = '0;
    logic [31:0] pend_addr = '0;
    logic [31:0] wa_first = '0;
    logic [31:0] wd_first = '0;
    logic [31:0] e;
    wr_t w;
    forever begin
      @(negedge clk);
      compared++;
      if (rd_req && wr_req) begin
        mismatched++;
        $display("FAIL req_overlap rd_req=%0b wr_req=%0b required not both high", rd_req, wr_req);
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
      if (manual) begin
        rd_state = 0; rd_stalling = 0; wr_stalling = 0; rd_gap = 0; wr_gap = 0;
        continue;
      end
      rd_valid = 1'b0;
      if (rd_state == 1) begin
        rd_ready = 1'b0;
        rd_cnt = stall_en ? $urandom_range(0, 5) : 0;
        rd_state = 2;
      end else if (rd_state == 0 && rd_req) begin
        if (!rd_stalling) begin
          rd_first = rd_addr;
          rd_stalling = 1;
          rd_gap = stall_en ? $urandom_range(0, 5) : 0;
        end
        if (rd_gap > 0) begin
          rd_gap--;
        end else begin
          rd_ready = 1'b1;
          rd_stalling = 0;
          pend_addr = rd_addr;
          reads++;
          rd_state = 1;
          compared++;
          if (rd_addr !== rd_first) begin
            mismatched++;
            $display("FAIL rd_addr_stable got=%h required=%h", rd_addr, rd_first);
          end
          compared++;
          if (exp_rd.size() == 0) begin
            mismatched++;
            $display("FAIL rd_unexpected got=%h required no read", rd_addr);
          end else begin
            e = exp_rd.pop_front();
            if (rd_addr !== e) begin
              mismatched++;
              $display("FAIL rd_addr got=%h required=%h", rd_addr, e);
            end
          end
        end
      end
      if (rd_state == 2) begin
        if (rd_cnt == 0) begin
          rd_valid = 1'b1;
          rd_data = mem_rd(pend_addr);
          rd_state = 0;
        end else begin
          rd_cnt--;
        end
      end
      wr_ready = 1'b0;
      if (wr_req) begin
        if (!wr_stalling) begin
          wa_first = wr_addr;
          wd_first = wr_data;
          wr_stalling = 1;
          wr_gap = stall_en ? $urandom_range(0, 5) : 0;
        end
        if (wr_gap > 0) begin
          wr_gap--;
        end else begin
          wr_ready = 1'b1;
          wr_stalling = 0;
          writes++;
          last_wr_data = wr_data;
          compared++;
          if (wr_addr !== wa_first || wr_data !== wd_first) begin
            mismatched++;
            $display("FAIL wr_stable got=%h/%h required=%h/%h", wr_addr, wr_data, wa_first, wd_first);
          end
          compared++;
          if (exp_wr.size() == 0) begin
            mismatched++;
            $display("FAIL wr_unexpected got=%h/%h required no write", wr_addr, wr_data);
          end else begin
            w = exp_wr.pop_front();
            if (wr_addr !== w.addr || wr_data !== w.data) begin
              mismatched++;
              $display("FAIL wr_result got=%h/%h required=%h/%h", wr_addr, wr_data, w.addr, w.data);
            end
          end
        end
      end
    end
  end

  task automatic fill_map(input logic [31:0] src, input int w, h, input int mode);
    for (int i = 0; i < w * h; i++)
      mem[src + 32'(4 * i)] = (mode == 0) ? 32'(i) : $urandom;
  endtask

  task automatic run_job(input logic [31:0] src, dst, input int w, h, input bit stall,
                         input bit poke, input string name);
    int ow, oh, r0, w0, d0, cyc;
    logic [31:0] v [4];
    wr_t wt;
    ow = w / 2;
    oh = h / 2;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        for (int k = 0; k < 4; k++) begin
          logic [31:0] a;
          a = src + 32'(4 * ((2 * oy + k / 2) * w + 2 * ox + k % 2));
          exp_rd.push_back(a);
          v[k] = mem_rd(a);
        end
        wt.addr = dst + 32'(4 * (oy * ow + ox));
        wt.data = win_max(v[0], v[1], v[2], v[3]);
        exp_wr.push_back(wt);
      end
    stall_en = stall;
    r0 = reads; w0 = writes; d0 = done_cnt; busy_seen = 0;
    @(negedge clk);
    start = 1'b1; src_base = src; dst_base = dst; width = DW'(w); height = DW'(h);
    @(negedge clk);
    start = 1'b0;
    src_base = 32'hFFFF_0000; dst_base = 32'hEEEE_0000; width = 16'd9; height = 16'd9;
    compared++;
    if (ow == 0 || oh == 0) begin
      if (done !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0) begin
        mismatched++;
        $display("FAIL %s start_resp done/busy/rd_req=%b%b%b required=100", name, done, busy, rd_req);
      end
    end else if (busy !== 1'b1 || rd_req !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s start_resp done/busy/rd_req=%b%b%b required=011", name, done, busy, rd_req);
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 10) begin
        start = 1'b1; src_base = 32'h0000_9000; dst_base = 32'h0000_A000;
        width = 16'd4; height = 16'd4;
      end
      if (poke && cyc == 11) start = 1'b0;
    end
    compared++;
    if (cyc >= 5000) begin
      mismatched++;
      $display("FAIL %s done_timeout cycles=%0d required done before 5000", name, cyc);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL %s done_pulses got=%0d required=1", name, done_cnt - d0);
    end
    compared++;
    if (reads - r0 != 4 * ow * oh || writes - w0 != ow * oh) begin
      mismatched++;
      $display("FAIL %s traffic reads=%0d writes=%0d required=%0d/%0d", name,
               reads - r0, writes - w0, 4 * ow * oh, ow * oh);
    end
    compared++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      mismatched++;
      $display("FAIL %s leftover rd=%0d wr=%0d required=0/0", name, exp_rd.size(), exp_wr.size());
      exp_rd.delete();
      exp_wr.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl busy/done/rd/wr=%b%b%b%b required=0000", busy, done, rd_req, wr_req);
    end
    compared++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      mismatched++;
      $display("FAIL reset_data rd_addr=%h wr_addr=%h wr_data=%h required=0", rd_addr, wr_addr, wr_data);
    end
  endtask

  task automatic test_basic;
    fill_map(32'h1000, 4, 4, 0);
    run_job(32'h1000, 32'h2000, 4, 4, 1'b0, 1'b0, "basic4x4");
  endtask

  task automatic test_signed;
    logic [31:0] req;
    mem[32'h3000] = -32'sd5; mem[32'h3004] = -32'sd2;
    mem[32'h3008] = -32'sd9; mem[32'h300C] = -32'sd7;
    run_job(32'h3000, 32'h3100, 2, 2, 1'b0, 1'b0, "neg_window");
`ifdef MAXSEQ_RELU_EN
    req = 32'h0000_0000;
`else
    req = 32'hFFFF_FFFE;
`endif
    compared++;
    if (last_wr_data !== req) begin
      mismatched++;
      $display("FAIL neg_window_value got=%h required=%h", last_wr_data, req);
    end
    mem[32'h3200] = 32'hFFFF_FFFF; mem[32'h3204] = 32'd3;
    mem[32'h3208] = 32'h8000_0000; mem[32'h320C] = 32'd2;
    run_job(32'h3200, 32'h3300, 2, 2, 1'b0, 1'b0, "mixed_window");
    compared++;
    if (last_wr_data !== 32'd3) begin
      mismatched++;
      $display("FAIL mixed_window_value got=%h required=%h", last_wr_data, 32'd3);
    end
  endtask

  task automatic test_odd_dims;
    fill_map(32'h4000, 5, 3, 1);
    run_job(32'h4000, 32'h4800, 5, 3, 1'b0, 1'b0, "odd5x3");
  endtask

  task automatic test_stalls;
    fill_map(32'h1000, 4, 4, 0);
    run_job(32'h1000, 32'h2000, 4, 4, 1'b1, 1'b0, "stall4x4");
    fill_map(32'h7000, 6, 4, 1);
    run_job(32'h7000, 32'h7800, 6, 4, 1'b1, 1'b1, "stall6x4_poke");
  endtask

  task automatic test_degenerate;
    int r0, w0;
    r0 = reads; w0 = writes;
    run_job(32'h5000, 32'h5800, 1, 8, 1'b0, 1'b0, "degen1x8");
    compared++;
    if (busy_seen || reads != r0 || writes != w0) begin
      mismatched++;
      $display("FAIL degen_quiet busy_seen=%0b reads=%0d writes=%0d required=0/0/0",
               busy_seen, reads - r0, writes - w0);
    end
  endtask

  task automatic test_reset_midop;
    bit bad;
    manual = 1;
    @(negedge clk);
    rd_ready = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0;
    fill_map(32'h5000, 2, 2, 0);
    start = 1'b1; src_base = 32'h5000; dst_base = 32'h6000; width = 16'd2; height = 16'd2;
    @(negedge clk);
    start = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    compared++;
    if (busy !== 1'b1 || rd_req !== 1'b0) begin
      mismatched++;
      $display("FAIL midop_rd_wait busy/rd_req=%b%b required=10", busy, rd_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_valid = 1'b1;
    rd_data = 32'h0000_0077;
    compared++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0) begin
      mismatched++;
      $display("FAIL midop_reset busy/rd/wr=%b%b%b required=000", busy, rd_req, wr_req);
    end
    @(negedge clk);
    rd_valid = 1'b0;
    bad = 0;
    repeat (6) begin
      if (busy || rd_req || wr_req || done) bad = 1;
      @(negedge clk);
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL midop_quiet activity=%0b required=0", bad);
    end
    manual = 0;
    @(negedge clk);
    run_job(32'h5000, 32'h6000, 2, 2, 1'b0, 1'b0, "after_reset2x2");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; width = '0; height = '0;
    rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0; wr_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_odd_dims();
    test_stalls();
    test_degenerate();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
